// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular word FIFO.
// Frames are start bit, NUM_DATA_BITS data bits LSB first, then one stop bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT  = 217,
  parameter int NUM_DATA_BITS = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_txValid,
  input  logic [NUM_DATA_BITS-1:0]      i_txByte,
  output logic                          o_txReady,
  output logic                          o_tx,
  output logic                          o_txActive,
  output logic                          o_txDone,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifoCount
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_DATA_BITS);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_DATA_BITS - 1);
  localparam logic [PW:0]   FULL     = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
  logic                     tx_q, tx_d;
  logic                     done_q, done_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW:0]              count_q, count_d;
  logic [NUM_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic                     push;
  logic                     pop;

  // Ready depends only on the registered count, so a full FIFO refuses a push
  // even when the serializer pops on the same edge.
  assign o_txReady   = (count_q != FULL);
  assign push        = i_txValid && o_txReady;
  assign o_tx        = tx_q;
  assign o_txDone    = done_q;
  assign o_txActive  = (state_q != IDLE);
  assign o_fifoCount = count_q;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_txByte;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // The line value is computed for the state being entered, so o_tx changes
  // on the same edge as the state transition and stays a plain flop output.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[NUM_DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          done_d    = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/arithmetic reference model checked every cycle,
// a mid-bit sampling receiver, and directed timing checks (plus a C=4, N=7 corner).
module tb_uart_tx_fifo;

  localparam int C = 217;
  localparam int N = 8;
  localparam int D = 4;
  localparam int T = (N + 2) * C;

  logic       clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       o_txReady, o_tx, o_txActive, o_txDone;
  logic [2:0] o_fifoCount;

  logic       valid2 = 1'b0;
  logic [6:0] byte2 = 7'h00;
  logic       ready2, tx2, active2, done2;
  logic [2:0] count2;

  initial forever #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .NUM_DATA_BITS(N), .FIFO_DEPTH(D)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_txValid(valid), .i_txByte(byte_in),
    .o_txReady(o_txReady), .o_tx(o_tx), .o_txActive(o_txActive),
    .o_txDone(o_txDone), .o_fifoCount(o_fifoCount));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .NUM_DATA_BITS(7), .FIFO_DEPTH(4)) u_dut2 (
    .i_clk(clk), .i_rst(i_rst), .i_txValid(valid2), .i_txByte(byte2),
    .o_txReady(ready2), .o_tx(tx2), .o_txActive(active2),
    .o_txDone(done2), .o_fifoCount(count2));

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: a word queue plus a frame-phase counter. Within a frame the
  // line level follows from phase / C: start, N data bits, then stop.
  logic [7:0] m_q[$];
  int         m_phase = -1;
  logic [7:0] m_word = 8'h00;
  logic       m_done = 1'b0;
  bit         m_push;

  initial forever begin
    @(posedge clk or posedge i_rst);
    if (i_rst) begin
      m_q.delete();
      m_phase = -1;
      m_done  = 1'b0;
    end else begin
      m_push = valid && (m_q.size() != D);
      m_done = 1'b0;
      if (m_phase < 0) begin
        if (m_q.size() != 0) begin
          m_word  = m_q.pop_front();
          m_phase = 0;
        end
      end else begin
        m_phase++;
        if (m_phase == T) begin
          m_phase = -1;
          m_done  = 1'b1;
        end
      end
      if (m_push) m_q.push_back(byte_in);
    end
  end

  function automatic logic exp_tx();
    int b;
    if (m_phase < 0) return 1'b1;
    b = m_phase / C;
    if (b == 0) return 1'b0;
    if (b <= N) return m_word[b-1];
    return 1'b1;
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_tx", 32'(o_tx), 32'(exp_tx()));
      check("model_active", 32'(o_txActive), 32'(m_phase >= 0));
      check("model_done", 32'(o_txDone), 32'(m_done));
      check("model_count", 32'(o_fifoCount), 32'(m_q.size()));
      check("model_ready", 32'(o_txReady), 32'(m_q.size() != D));
    end
  end

  // Mid-bit sampling receiver on the serial line.
  int         rx_cnt = 0;
  int         rx_k;
  bit         rx_busy = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  logic       rx_bits[$];
  logic [7:0] rx_bytes[$];
  int         done_cyc[$];

  initial forever begin
    @(negedge clk);
    if (i_rst) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (o_tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
    end
    if (rx_busy && (rx_cnt % C == C / 2)) begin
      rx_k = rx_cnt / C;
      rx_bits.push_back(o_tx);
      if (rx_k >= 1 && rx_k <= N) rx_sh[rx_k-1] = o_tx;
      if (rx_k == N + 1) begin
        rx_bytes.push_back(rx_sh);
        rx_busy = 1'b0;
      end
    end
    if (o_txDone === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic push_word(input logic [7:0] w, output int e);
    bit rdy;
    valid   = 1'b1;
    byte_in = w;
    e       = -1;
    for (int k = 0; k < 5000; k++) begin
      rdy = o_txReady;
      @(negedge clk);
      if (rdy) begin
        e = cyc;
        break;
      end
    end
    valid   = 1'b0;
    byte_in = 8'($urandom);
    if (e < 0) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_logs();
    rx_bits.delete();
    rx_bytes.delete();
    done_cyc.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (rx_bytes.size() >= n && !o_txActive && o_fifoCount == 0) break;
      @(negedge clk);
    end
    if (k == budget) check("wait_bytes_timeout", 32'(rx_bytes.size()), 32'(n));
    repeat (20) @(negedge clk);
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_bytes.size()) return 32'(rx_bytes[i]);
    return 32'hFFFF_FFFF;
  endfunction

  int         e, n0, low_s, low_e, done_at;
  int         eb[6];
  logic [7:0] burst[6];
  logic [7:0] loopw[4];
  logic [9:0] seq;
  logic [9:0] seq_exp;
  logic [6:0] corner_exp;
  logic       tr[48];
  logic       dn[48];
  logic       ac[48];

  initial begin
    burst      = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h81, 8'h99};
    loopw      = '{8'h37, 8'h00, 8'hFF, 8'hAA};
    seq_exp    = 10'b1001101110;
    corner_exp = 7'b1010101;

    #1 i_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(o_tx), 32'd1);
    check("rst_ready", 32'(o_txReady), 32'd1);
    check("rst_active", 32'(o_txActive), 32'd0);
    check("rst_done", 32'(o_txDone), 32'd0);
    check("rst_count", 32'(o_fifoCount), 32'd0);
    check("rst2_tx", 32'(tx2), 32'd1);
    check("rst2_ready", 32'(ready2), 32'd1);
    check("rst2_count", 32'(count2), 32'd0);
    #2 i_rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset during data bit 3 of 0x37
    clear_logs();
    push_word(8'h37, e);
    while (cyc < e + 900) @(negedge clk);
    check("midframe_bit3_low", 32'(o_tx), 32'd0);
    n0 = done_cyc.size();
    #2 i_rst = 1'b1;
    #1;
    check("midrst_tx", 32'(o_tx), 32'd1);
    check("midrst_count", 32'(o_fifoCount), 32'd0);
    check("midrst_ready", 32'(o_txReady), 32'd1);
    check("midrst_active", 32'(o_txActive), 32'd0);
    @(negedge clk);
    #2 i_rst = 1'b0;
    repeat (2500) @(negedge clk);
    check("midrst_no_done", 32'(done_cyc.size()), 32'(n0));
    check("midrst_no_byte", 32'(rx_bytes.size()), 32'd0);
    check("midrst_line_idle", 32'(o_tx), 32'd1);

    // Single word 0x37
    clear_logs();
    push_word(8'h37, e);
    low_s = -1; low_e = -1; done_at = -1;
    for (int k = 0; k < 3000; k++) begin
      if (o_tx === 1'b0 && low_s < 0) low_s = cyc;
      if (o_tx === 1'b1 && low_s >= 0 && low_e < 0) low_e = cyc;
      if (o_txDone === 1'b1) begin
        done_at = cyc;
        break;
      end
      @(negedge clk);
    end
    check("single_low_start", 32'(low_s - e), 32'd1);
    check("single_low_end", 32'(low_e - e), 32'd218);
    check("single_done", 32'(done_at - e), 32'd2171);
    seq = '0;
    for (int i = 0; i < 10; i++)
      if (i < rx_bits.size()) seq[i] = rx_bits[i];
    check("single_nbits", 32'(rx_bits.size()), 32'd10);
    check("single_sequence", 32'(seq), 32'(seq_exp));
    repeat (20) @(negedge clk);

    // Burst of five into depth 4, sixth held while full
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      push_word(burst[i], eb[i]);
      if (i == 4) check("burst_ready_low", 32'(o_txReady), 32'd0);
    end
    check("burst_accept_by_E4", 32'(eb[4] - eb[0]), 32'd4);
    check("full_push_after_2nd_pop", 32'(eb[5] - eb[0]), 32'd2173);
    wait_bytes(6, 15000);
    check("burst_nbytes", 32'(rx_bytes.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("burst_byte%0d", i), rx_at(i), 32'(burst[i]));
    check("burst_ndone", 32'(done_cyc.size()), 32'd6);
    if (done_cyc.size() == 6) begin
      check("burst_first_done", 32'(done_cyc[0] - eb[0]), 32'd2171);
      for (int i = 1; i < 6; i++)
        check($sformatf("burst_spacing%0d", i), 32'(done_cyc[i] - done_cyc[i-1]), 32'd2171);
    end

    // Loopback through the receiver
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(loopw[i], e);
    wait_bytes(4, 12000);
    check("loop_nbytes", 32'(rx_bytes.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("loop_byte%0d", i), rx_at(i), 32'(loopw[i]));

    // Corner: C=4, N=7, word 0x55
    valid2 = 1'b1;
    byte2  = 7'h55;
    check("corner_ready", 32'(ready2), 32'd1);
    @(negedge clk);
    valid2 = 1'b0;
    check("corner_count", 32'(count2), 32'd1);
    for (int j = 0; j < 48; j++) begin
      @(negedge clk);
      tr[j] = tx2;
      dn[j] = done2;
      ac[j] = active2;
    end
    low_s = -1; done_at = -1;
    for (int j = 47; j >= 0; j--) begin
      if (tr[j] === 1'b0) low_s = j;
      if (dn[j] === 1'b1) done_at = j;
    end
    check("corner_start_low", 32'(low_s), 32'd0);
    check("corner_frame_len", 32'(done_at - low_s), 32'd36);
    for (int i = 0; i < 7; i++)
      check($sformatf("corner_bit%0d", i), 32'(tr[(i + 1) * 4 + 2]), 32'(corner_exp[i]));
    check("corner_stop", 32'(tr[34]), 32'd1);
    check("corner_active_end", 32'({ac[35], ac[36]}), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
